receiver: RTL

UART receive block: deserialises the 11-bit frame format used on the telemetry link (start, 8 data bits LSB first, even parity, 1 stop). It oversamples the asynchronous RX pin with the system clock, validates the start bit, checks parity and stop bit, and pushes good bytes into the downstream RX FIFO through a one-cycle write strobe. It sits between the board RX pin and the RX FIFO, opposite the transmit path.

---
 rtl/receiver_if.sv | 41 ++++
 rtl/receiver.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/receiver_if.sv
`default_nettype none
// ============================================================================
//  Module   : receiver_if
//  Purpose  : RX pin / RX-FIFO side bundle of the UART receiver.
//  Revision : 1.0  initial release
// ============================================================================
interface receiver_if;
  logic       receive_wire;
  logic       fifo_full;
  logic [7:0] data_out;
  logic       fifo_write;
  logic       parity_error;
  logic       framing_error;
  logic       overrun_error;
  logic       state_busy;

  // Drives the line and FIFO status, observes the receiver
  modport master (
    output receive_wire,
    output fifo_full,
    input  data_out,
    input  fifo_write,
    input  parity_error,
    input  framing_error,
    input  overrun_error,
    input  state_busy
  );

  // The receiver itself
  modport slave (
    input  receive_wire,
    input  fifo_full,
    output data_out,
    output fifo_write,
    output parity_error,
    output framing_error,
    output overrun_error,
    output state_busy
  );
endinterface
`default_nettype wire

// File: rtl/receiver.sv
`default_nettype none
// ============================================================================
//  Module   : receiver
//  Purpose  : UART RX, 8 data bits LSB first, even parity, 1 stop bit;
//             pushes good bytes to the RX FIFO with a one-cycle strobe.
//  Revision : 1.0  initial release
// ============================================================================
module receiver #(
  parameter int CLOCK_FREQ = 50_000_000,
  parameter int BAUD       = 9600
) (
  input  logic       clk,
  input  logic       rst,
  receiver_if.slave  rx_if
);

  localparam int unsigned c_cycles_per_bit = CLOCK_FREQ / BAUD;
  localparam int unsigned c_half_bit       = c_cycles_per_bit / 2;
  localparam logic [31:0] c_bit_last       = 32'(c_cycles_per_bit - 1);
  localparam logic [31:0] c_half_last      = 32'(c_half_bit - 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    START   = 3'd1,
    DATA    = 3'd2,
    PARITY  = 3'd3,
    STOP    = 3'd4,
    RECOVER = 3'd5
  } state_t;

  state_t      state_q, state_d;
  logic [1:0]  sync_q;
  logic [31:0] cnt_q, cnt_d;
  logic [2:0]  idx_q, idx_d;
  logic [7:0]  shift_q, shift_d;
  logic        par_bad_q, par_bad_d;
  logic [7:0]  data_q, data_d;
  logic        write_q, write_d;
  logic        perr_q, perr_d;
  logic        ferr_q, ferr_d;
  logic        oerr_q, oerr_d;
  logic        w_rx_s;

  assign w_rx_s = sync_q[1];

  // Synchroniser resets to the idle line level so reset never fakes a start bit
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q <= 2'b11;
    end else begin
      sync_q <= {sync_q[0], rx_if.receive_wire};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      idx_q     <= '0;
      shift_q   <= '0;
      par_bad_q <= 1'b0;
      data_q    <= '0;
      write_q   <= 1'b0;
      perr_q    <= 1'b0;
      ferr_q    <= 1'b0;
      oerr_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      shift_q   <= shift_d;
      par_bad_q <= par_bad_d;
      data_q    <= data_d;
      write_q   <= write_d;
      perr_q    <= perr_d;
      ferr_q    <= ferr_d;
      oerr_q    <= oerr_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q + 32'd1;
    idx_d     = idx_q;
    shift_d   = shift_q;
    par_bad_d = par_bad_q;
    data_d    = data_q;
    write_d   = 1'b0;
    perr_d    = 1'b0;
    ferr_d    = 1'b0;
    oerr_d    = 1'b0;

    unique case (state_q)
      IDLE: begin
        idx_d = '0;
        if (!w_rx_s) begin
          state_d = START;
        end
      end
      START: begin
        if (cnt_q == c_half_last) begin
          state_d = w_rx_s ? IDLE : DATA;
        end
      end
      DATA: begin
        if (cnt_q == c_bit_last) begin
          shift_d[idx_q] = w_rx_s;
          idx_d          = idx_q + 3'd1;
          cnt_d          = '0;
          if (idx_q == 3'd7) begin
            state_d = PARITY;
          end
        end
      end
      PARITY: begin
        if (cnt_q == c_bit_last) begin
          par_bad_d = (w_rx_s != ^shift_q);
          state_d   = STOP;
        end
      end
      STOP: begin
        // Leave mid stop bit so a back-to-back start edge is not missed
        if (cnt_q == c_bit_last) begin
          if (!w_rx_s) begin
            ferr_d  = 1'b1;
            state_d = RECOVER;
          end else if (par_bad_q) begin
            perr_d  = 1'b1;
            state_d = IDLE;
          end else if (rx_if.fifo_full) begin
            oerr_d  = 1'b1;
            state_d = IDLE;
          end else begin
            write_d = 1'b1;
            data_d  = shift_q;
            state_d = IDLE;
          end
        end
      end
      RECOVER: begin
        if (w_rx_s) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (state_d != state_q) begin
      cnt_d = '0;
    end
  end

  assign rx_if.data_out      = data_q;
  assign rx_if.fifo_write    = write_q;
  assign rx_if.parity_error  = perr_q;
  assign rx_if.framing_error = ferr_q;
  assign rx_if.overrun_error = oerr_q;
  assign rx_if.state_busy    = (state_q != IDLE);

endmodule
`default_nettype wire
